// File: rtl/shift_transmitter.sv
`default_nettype none
// ============================================================================
// shift_transmitter - framed parallel-to-serial transmitter (start/data/stop)
// Rev 1.0
// ============================================================================
module shift_transmitter #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int LEFT         = 1
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             serial,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int IDX_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(WIDTH);
    localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
    logic             r_serial, w_serial_nxt;
    logic             r_done, w_done_nxt;

    logic             w_bit_end;
    logic             w_out_bit;
    logic [WIDTH-1:0] w_shifted;

    // Bit order selects which end of the shift register feeds the line.
    generate
        if (LEFT != 0) begin : g_msb_first
            assign w_out_bit = r_shreg[WIDTH-1];
            assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_out_bit = r_shreg[0];
            assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
        end
    endgenerate

    assign w_bit_end = (r_cnt == C_CNT_LAST);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_shreg_nxt  = r_shreg;
        w_serial_nxt = r_serial;
        w_done_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                w_serial_nxt = 1'b1;
                if (valid) begin
                    w_state_nxt  = START;
                    w_cnt_nxt    = '0;
                    w_idx_nxt    = '0;
                    w_shreg_nxt  = data;
                    w_serial_nxt = 1'b0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt  = DATA;
                    w_cnt_nxt    = '0;
                    w_idx_nxt    = C_IDX_ONE;
                    w_serial_nxt = w_out_bit;
                    w_shreg_nxt  = w_shifted;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_idx == C_IDX_LAST) begin
                        w_state_nxt  = STOP;
                        w_serial_nxt = 1'b1;
                    end else begin
                        w_idx_nxt    = r_idx + C_IDX_ONE;
                        w_serial_nxt = w_out_bit;
                        w_shreg_nxt  = w_shifted;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_state_nxt  = IDLE;
                    w_cnt_nxt    = '0;
                    w_idx_nxt    = '0;
                    w_serial_nxt = 1'b1;
                    w_done_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_serial_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shreg  <= '0;
            r_serial <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_shreg  <= w_shreg_nxt;
            r_serial <= w_serial_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign ready  = (r_state == IDLE);
    assign busy   = (r_state != IDLE);
    assign serial = r_serial;
    assign done   = r_done;

endmodule
`default_nettype wire
